fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller.
// Requests one word at a time from instruction memory, holds it for the
// downstream stage, and follows branch/jump redirects. Illegal fetch
// targets stop the fetcher in HALT with a sticky fault.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int unsigned IMEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fault,
    output logic [15:0] issue_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Bounds are kept 33 bits wide so the upper limit cannot wrap.
    localparam logic [32:0] FIRST_ADDR = {1'b0, RESET_PC};
    localparam logic [32:0] LAST_ADDR  = FIRST_ADDR + 33'(4 * IMEM_WORDS) - 33'd4;

    // A fetch address is legal when word aligned and inside instruction memory.
    function automatic logic addr_legal(input logic [31:0] addr);
        logic [32:0] wide;
        wide = {1'b0, addr};
        return (addr[1:0] == 2'b00) && (wide >= FIRST_ADDR) && (wide <= LAST_ADDR);
    endfunction

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_next;
    logic [31:0] instr_next;
    logic        fault_next;
    logic [15:0] count_next;
    logic        pend_valid;
    logic        pend_valid_next;
    logic [31:0] pend_pc;
    logic [31:0] pend_pc_next;
    logic [31:0] seq_pc;
    logic [31:0] fetch_target;

    // Same-cycle redirect wins over an older pending redirect.
    assign seq_pc       = pc + 32'd4;
    assign fetch_target = redirect_valid ? redirect_pc : pend_pc;

    // Outputs depend only on registered state.
    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);

    // Next-state and datapath decisions; every target is checked as it is applied.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        instr_next      = instr;
        fault_next      = fault;
        count_next      = issue_count;
        pend_valid_next = pend_valid;
        pend_pc_next    = pend_pc;

        case (state)
            IDLE: begin
                state_next = FETCH;
            end

            FETCH: begin
                if (imem_ready) begin
                    if (redirect_valid || pend_valid) begin
                        pend_valid_next = 1'b0;
                        pc_next         = fetch_target;
                        if (!addr_legal(fetch_target)) begin
                            state_next = HALT;
                            fault_next = 1'b1;
                        end
                    end else begin
                        instr_next = imem_rdata;
                        state_next = HOLD;
                    end
                end else if (redirect_valid) begin
                    pend_valid_next = 1'b1;
                    pend_pc_next    = redirect_pc;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    pc_next         = redirect_pc;
                    pend_valid_next = 1'b0;
                    if (addr_legal(redirect_pc)) begin
                        state_next = FETCH;
                    end else begin
                        state_next = HALT;
                        fault_next = 1'b1;
                    end
                end else if (!stall) begin
                    count_next = issue_count + 16'd1;
                    pc_next    = seq_pc;
                    if (addr_legal(seq_pc)) begin
                        state_next = FETCH;
                    end else begin
                        state_next = HALT;
                        fault_next = 1'b1;
                    end
                end
            end

            HALT: begin
                state_next = HALT;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            fault       <= 1'b0;
            issue_count <= 16'd0;
            pend_valid  <= 1'b0;
            pend_pc     <= 32'd0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr       <= instr_next;
            fault       <= fault_next;
            issue_count <= count_next;
            pend_valid  <= pend_valid_next;
            pend_pc     <= pend_pc_next;
        end
    end

endmodule
